// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared constants and FSM encoding for the temperature BCD converter
//
// Purpose: display digit codes, scaling constants and the converter state
// encoding used by temp_bcd_seq and bcd_dabble_seq.
// Ports: none (package).
package temp_pkg;

  localparam logic [3:0] SIGN_POS   = 4'hA;
  localparam logic [3:0] SIGN_NEG   = 4'hB;
  localparam logic [3:0] DIG_BLANK  = 4'hF;
  localparam int         FRAC_SCALE = 625;
  localparam int         BCD_DIGITS = 8;
  localparam int         SCALED_W   = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/temp_bcd_seq_if.sv
// rtl/temp_bcd_seq_if.sv - sample-in / display-out bundle of the temperature converter
//
// Purpose: groups the sensor sample handshake and the display outputs.
// Signals:
//   t_valid   sample valid (sensor -> converter)
//   t_data    signed sample, 1/16 degC (sensor -> converter)
//   t_ready   converter can accept a sample
//   dis_data  {sign, integer digits MS..LS, fraction digits}, DW bits
//   dis_valid one-cycle pulse: dis_data/en/ovf just updated
//   en        hysteretic alarm flag
//   ovf       integer part does not fit the integer field
// Modports: master = sensor/display side, slave = converter.
interface temp_bcd_seq_if #(
  parameter int DW = 24
);
  logic          t_valid;
  logic [15:0]   t_data;
  logic          t_ready;
  logic [DW-1:0] dis_data;
  logic          dis_valid;
  logic          en;
  logic          ovf;

  modport master (
    output t_valid, t_data,
    input  t_ready, dis_data, dis_valid, en, ovf
  );

  modport slave (
    input  t_valid, t_data,
    output t_ready, dis_data, dis_valid, en, ovf
  );
endinterface

// File: rtl/bcd_dabble_seq.sv
// rtl/bcd_dabble_seq.sv - iterative shift-add-3 binary to 8-digit BCD engine
//
// Purpose: converts a SCALED_W-bit binary value into BCD_DIGITS packed BCD
// digits, one bit per clock.
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   start  load bin and begin a conversion (ignored unless idle by the caller)
//   bin    binary value to convert
//   busy   conversion in progress
//   done   high in the cycle where bcd holds the final result (count == SCALED_W-1)
//   bcd    packed BCD result, digit 0 in bits [3:0]
module bcd_dabble_seq
  import temp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SCALED_W-1:0]       bin,
  output logic                      busy,
  output logic                      done,
  output logic [4*BCD_DIGITS-1:0]   bcd
);

  localparam logic [SCALED_W-1:0] LAST = SCALED_W'(SCALED_W - 1);

  logic [SCALED_W-1:0]     sh_q,   sh_d;
  logic [SCALED_W-1:0]     cnt_q,  cnt_d;
  logic [4*BCD_DIGITS-1:0] bcd_q,  bcd_d;
  logic [4*BCD_DIGITS-1:0] adj;
  logic                    busy_q, busy_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    sh_d   = sh_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    busy_d = busy_q;

    if (start) begin
      // The first shift is folded into the load: all digits start at zero,
      // so no add-3 correction can apply before it.
      bcd_d  = {{(4*BCD_DIGITS-1){1'b0}}, bin[SCALED_W-1]};
      sh_d   = {bin[SCALED_W-2:0], 1'b0};
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end else begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d         = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);
  assign bcd  = bcd_q;

endmodule

// File: rtl/temp_bcd_seq.sv
// rtl/temp_bcd_seq.sv - sequential DS18B20 sample to sign + BCD display converter
//
// Purpose: accepts one signed 1/16 degC sample, converts |t|*625 with the
// iterative dabble engine and presents sign, integer and truncated fraction
// digits, an over-range flag and a hysteretic alarm flag.
// Ports:
//   sys_clk  clock
//   sys_rst  synchronous active-high reset
//   bus      temp_bcd_seq_if.slave: t_valid/t_data/t_ready sample handshake,
//            dis_data/dis_valid/en/ovf display outputs
module temp_bcd_seq
  import temp_pkg::*;
#(
  parameter int INT_DIGITS  = 2,
  parameter int FRAC_DIGITS = 3,
  parameter int BLANK_LZ    = 0,
  parameter int ALARM_HI_Q4 = 480,
  parameter int ALARM_LO_Q4 = 95,
  parameter int HYST_Q4     = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  temp_bcd_seq_if.slave      bus
);

  localparam int DW = 4 * (1 + INT_DIGITS + FRAC_DIGITS);
  localparam logic [DW-1:0] RESET_DISP = {SIGN_POS, {(DW-4){1'b0}}};

  state_t          state_q;
  logic [15:0]     sample_q;
  logic            t_ready_q;
  logic            dis_valid_q;
  logic            en_q, en_d;
  logic            ovf_q, ovf_d;
  logic [DW-1:0]   dis_data_q, dis_data_d;

  logic [15:0]             mag;
  logic [SCALED_W-1:0]     scaled;
  logic signed [31:0]      t_s;
  logic                    dab_busy, dab_done;
  logic [4*BCD_DIGITS-1:0] dab_bcd;
  logic                    lead;
  logic [3:0]              digit;

  // |t| as unsigned 16 bits; 0x8000 maps to 32768. Times 625 gives temp*10^4.
  assign mag    = sample_q[15] ? (~sample_q + 16'd1) : sample_q;
  assign scaled = SCALED_W'(mag) * SCALED_W'(FRAC_SCALE);
  assign t_s    = {{16{sample_q[15]}}, sample_q};

  bcd_dabble_seq u_dabble (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (state_q == ST_PREP),
    .bin   (scaled),
    .busy  (dab_busy),
    .done  (dab_done),
    .bcd   (dab_bcd)
  );

  // Field select, over-range and leading-zero blanking on the finished digits.
  // Digits d7..d4 are 10^3..10^0, d3..d0 are 10^-1..10^-4.
  always_comb begin
    ovf_d      = 1'b0;
    dis_data_d = '0;
    lead       = 1'b1;
    digit      = '0;

    for (int k = 4; k < BCD_DIGITS; k++) begin
      if (k >= 4 + INT_DIGITS && dab_bcd[4*k +: 4] != 4'd0) ovf_d = 1'b1;
    end

    dis_data_d[4*(FRAC_DIGITS+INT_DIGITS) +: 4] = sample_q[15] ? SIGN_NEG : SIGN_POS;

    for (int f = 0; f < FRAC_DIGITS; f++) begin
      dis_data_d[4*(FRAC_DIGITS-1-f) +: 4] = dab_bcd[4*(3-f) +: 4];
    end

    // Walk integer digits from the most significant down; blanking stops at
    // the first nonzero digit and never reaches the ones digit (j == 0).
    for (int j = INT_DIGITS - 1; j >= 0; j--) begin
      digit = dab_bcd[4*(4+j) +: 4];
      if (ovf_d) begin
        digit = 4'd9;
      end else if (BLANK_LZ != 0 && j != 0 && lead && digit == 4'd0) begin
        digit = DIG_BLANK;
      end else begin
        lead = 1'b0;
      end
      dis_data_d[4*(FRAC_DIGITS+j) +: 4] = digit;
    end
  end

  // Alarm with hysteresis: set at or beyond either limit, clear only once
  // the sample is strictly inside the band shrunk by HYST_Q4, else hold.
  always_comb begin
    en_d = en_q;
    if (t_s >= ALARM_HI_Q4 || t_s <= ALARM_LO_Q4) begin
      en_d = 1'b1;
    end else if (t_s > ALARM_LO_Q4 + HYST_Q4 && t_s < ALARM_HI_Q4 - HYST_Q4) begin
      en_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      t_ready_q   <= 1'b1;
      dis_valid_q <= 1'b0;
      en_q        <= 1'b0;
      ovf_q       <= 1'b0;
      dis_data_q  <= RESET_DISP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.t_valid && t_ready_q) begin
            sample_q  <= bus.t_data;
            t_ready_q <= 1'b0;
            state_q   <= ST_PREP;
          end
        end
        ST_PREP: begin
          state_q <= ST_CONV;
        end
        ST_CONV: begin
          // Outputs are captured on the edge into DONE so they are valid
          // for the whole DONE cycle alongside dis_valid.
          if (dab_done) begin
            dis_data_q  <= dis_data_d;
            ovf_q       <= ovf_d;
            en_q        <= en_d;
            dis_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          dis_valid_q <= 1'b0;
          t_ready_q   <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.t_ready   = t_ready_q;
  assign bus.dis_data  = dis_data_q;
  assign bus.dis_valid = dis_valid_q;
  assign bus.en        = en_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_temp_bcd_seq.sv
// tb/tb_temp_bcd_seq.sv - directed self-checking bench for temp_bcd_seq
module tb_temp_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        t_valid;
  logic [15:0] t_data;
  int          vectors = 0;
  int          miscompares = 0;
  int          lat;
  int          pulses;

  logic [23:0] exp_stream [4] = '{24'hA00000, 24'hA28000, 24'hA56000, 24'hA84000};

  always #5 clk = ~clk;

  temp_bcd_seq_if #(.DW(24)) if0 ();
  temp_bcd_seq_if #(.DW(28)) if1 ();
  temp_bcd_seq_if #(.DW(24)) if2 ();

  assign if0.t_valid = t_valid;
  assign if0.t_data  = t_data;
  assign if1.t_valid = t_valid;
  assign if1.t_data  = t_data;
  assign if2.t_valid = t_valid;
  assign if2.t_data  = t_data;

  temp_bcd_seq dut0 (.sys_clk(clk), .sys_rst(rst), .bus(if0));
  temp_bcd_seq #(.INT_DIGITS(3)) dut1 (.sys_clk(clk), .sys_rst(rst), .bus(if1));
  temp_bcd_seq #(.BLANK_LZ(1)) dut2 (.sys_clk(clk), .sys_rst(rst), .bus(if2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!if0.t_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Present one sample; returns at the negedge where dis_valid is seen,
  // with lat = cycles from the accepting edge (bounded at 64).
  task automatic send(input logic [15:0] d);
    wait_ready();
    t_valid = 1'b1;
    t_data  = d;
    @(negedge clk);
    t_valid = 1'b0;
    lat = 1;
    while (!if0.dis_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    t_valid = 1'b0;
    t_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_t_ready", if0.t_ready, 1);
    check("rst_dis_valid", if0.dis_valid, 0);
    check("rst_en", if0.en, 0);
    check("rst_ovf", if0.ovf, 0);
    check("rst_dis_data", if0.dis_data, 24'hA00000);
    check("rst_dis_data_i3", if1.dis_data, 28'hA000000);

    send(16'h0191);
    check("lat_0191", lat, 27);
    check("ready_during_valid", if0.t_ready, 0);
    check("data_0191", if0.dis_data, 24'hA25062);
    check("en_0191", if0.en, 0);
    check("ovf_0191", if0.ovf, 0);
    check("data_0191_i3", if1.dis_data, 28'hA025062);
    check("data_0191_blank", if2.dis_data, 24'hA25062);
    @(negedge clk);
    check("valid_pulse_len", if0.dis_valid, 0);
    check("ready_after_valid", if0.t_ready, 1);

    send(16'hFF5E);
    check("data_ff5e", if0.dis_data, 24'hB10125);
    check("en_ff5e", if0.en, 1);
    send(16'h0000);
    check("data_0000", if0.dis_data, 24'hA00000);
    check("en_0000", if0.en, 1);
    check("data_0000_blank", if2.dis_data, 24'hAF0000);
    send(16'hFC90);
    check("data_fc90", if0.dis_data, 24'hB55000);

    send(16'h01E0);
    check("data_01e0", if0.dis_data, 24'hA30000);
    check("en_01e0", if0.en, 1);
    send(16'h01D9);
    check("en_01d9_hold", if0.en, 1);
    send(16'h01D7);
    check("en_01d7_clear", if0.en, 0);
    send(16'h0060);
    check("en_0060_hold", if0.en, 0);
    send(16'h005F);
    check("en_005f_set", if0.en, 1);
    check("data_005f", if0.dis_data, 24'hA05937);

    send(16'h07D0);
    check("data_07d0", if0.dis_data, 24'hA99000);
    check("ovf_07d0", if0.ovf, 1);
    check("data_07d0_i3", if1.dis_data, 28'hA125000);
    check("ovf_07d0_i3", if1.ovf, 0);
    check("data_07d0_blank", if2.dis_data, 24'hA99000);
    send(16'h0050);
    check("data_0050_blank", if2.dis_data, 24'hAF5000);
    check("data_0050", if0.dis_data, 24'hA05000);
    check("ovf_0050", if0.ovf, 0);
    send(16'h8000);
    check("data_8000", if0.dis_data, 24'hB99000);
    check("ovf_8000", if0.ovf, 1);
    check("data_8000_i3", if1.dis_data, 28'hB999000);

    // t_valid held high with data changing every cycle.
    wait_ready();
    pulses = 0;
    for (int i = 0; i < 140; i++) begin
      if (if0.dis_valid) begin
        if (pulses < 4) check($sformatf("stream_%0d", pulses), if0.dis_data, exp_stream[pulses]);
        pulses++;
      end
      if (i < 100) begin
        t_valid = 1'b1;
        t_data  = 16'(i * 16);
      end else begin
        t_valid = 1'b0;
      end
      @(negedge clk);
    end
    t_valid = 1'b0;
    check("stream_count", pulses, 4);

    // Reset in the middle of CONV.
    wait_ready();
    t_valid = 1'b1;
    t_data  = 16'h0191;
    @(negedge clk);
    t_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (if0.dis_valid) pulses++;
      @(negedge clk);
    end
    check("midrst_no_valid", pulses, 0);
    check("midrst_dis_data", if0.dis_data, 24'hA00000);
    check("midrst_en", if0.en, 0);
    check("midrst_ovf", if0.ovf, 0);
    check("midrst_t_ready", if0.t_ready, 1);

    send(16'h0191);
    check("post_rst_lat", lat, 27);
    check("post_rst_data", if0.dis_data, 24'hA25062);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
